adder_and_not_32: RTL and testbench

ADDER_AND_NOT_32 -- requirements
Module: adder_and_not_32

---
 rtl/adder_and_not_32_pkg.sv | 21 ++
 rtl/adder_32_core.sv | 37 +++
 rtl/adder_and_not_32.sv | 110 +++++++++++
 tb/tb_adder_and_not_32.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/adder_and_not_32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_and_not_32_pkg
// Purpose  : Shared operation encodings and defaults for adder_and_not_32.
// Contents : op_e - 2-bit operation select (ADD, AND, NOT, reserved)
//            DEFAULT_WIDTH - default datapath width
// Revision : 1.0 - initial release
// ============================================================================
package adder_and_not_32_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_AND  = 2'b01,
    OP_NOT  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

endpackage : adder_and_not_32_pkg
`default_nettype wire

// File: rtl/adder_32_core.sv
`default_nettype none
// ============================================================================
// Module   : adder_32_core
// Purpose  : Purely combinational ripple-carry adder; cin enters bit 0 and
//            the carry ripples up to bit WIDTH-1.
// Ports    : a, b  - addends (WIDTH bits)
//            cin   - carry into bit 0
//            sum   - a + b + cin modulo 2^WIDTH
//            cout  - carry out of bit WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module adder_32_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic half;
    assign half         = a[i] ^ b[i];
    assign sum[i]       = half ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & half);
  end

  assign cout = carry[WIDTH];

endmodule : adder_32_core
`default_nettype wire

// File: rtl/adder_and_not_32.sv
`default_nettype none
// ============================================================================
// Module   : adder_and_not_32
// Purpose  : Single-cycle ALU slice: ADD (ripple-carry), bitwise AND, bitwise
//            NOT, plus a reserved op that yields zero. Results are registered
//            with exactly one cycle of latency and no backpressure.
// Ports    : clk       - clock, all state updates on rising edge
//            rst_n     - synchronous active-low reset (wins over in_valid)
//            in_valid  - qualifies op/a/b/cin
//            op        - 00 ADD, 01 AND, 10 NOT, 11 reserved
//            a, b, cin - operands (b unused for NOT, cin used only for ADD)
//            out_valid - result/cout/zero carry a fresh result
//            result    - registered result
//            cout      - registered ADD carry-out (0 for other ops)
//            zero      - registered result is all zeros (0 if disabled)
// Revision : 1.0 - initial release
// ============================================================================
module adder_and_not_32
  import adder_and_not_32_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter bit ZERO_FLAG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout
  ,
  output logic             zero
);

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] result_d;
  logic             cout_d;

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;

  adder_32_core #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Output mux; carry-out is only meaningful for ADD.
  always_comb begin
    result_d = '0;
    cout_d   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        result_d = add_sum;
        cout_d   = add_cout;
      end
      OP_AND:  result_d = a & b;
      OP_NOT:  result_d = ~a;
      default: result_d = '0;
    endcase
  end

  // out_valid follows in_valid every cycle; payload only loads on a valid
  // cycle so it holds across idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        cout_q   <= cout_d;
      end
    end
  end

  // The zero flag is kept in its own register, loaded alongside result, so it
  // always reflects the held result yet still reads 0 straight out of reset
  // (where result is 0 but no operation has completed).
  if (ZERO_FLAG_EN) begin : g_zero_en
    logic zero_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        zero_q <= 1'b0;
      end else if (in_valid) begin
        zero_q <= (result_d == '0);
      end
    end
    assign zero = zero_q;
  end else begin : g_zero_dis
    assign zero = 1'b0;
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign cout      = cout_q;

endmodule : adder_and_not_32
`default_nettype wire

// File: tb/tb_adder_and_not_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_and_not_32
// Purpose  : Self-checking bench for adder_and_not_32: directed vectors for
//            the documented cases, then randomized traffic compared against a
//            behavioural model built from plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_and_not_32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the outputs should show after the latest edge.
  logic         m_valid  = 1'b0;
  logic [W-1:0] m_result = '0;
  logic         m_cout   = 1'b0;
  logic         m_zero   = 1'b0;

  always #5 clk = ~clk;

  adder_and_not_32 #(
    .WIDTH        (W),
    .ZERO_FLAG_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .result    (result),
    .cout      (cout),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision integer arithmetic, result is the low W bits.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, output logic [W-1:0] r, output logic co);
    longint unsigned s;
    case (o)
      2'd0: begin
        s  = longint'(x) + longint'(y) + longint'(c);
        r  = s[W-1:0];
        co = s[W];
      end
      2'd1: begin r = x & y; co = 1'b0; end
      2'd2: begin r = ~x;    co = 1'b0; end
      default: begin r = '0; co = 1'b0; end
    endcase
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check after it.
  task automatic cycle(input string tag, input logic r_n, input logic v, input logic [1:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W-1:0] r;
    logic         co;
    rst_n = r_n; in_valid = v; op = o; a = x; b = y; cin = c;
    @(posedge clk);
    if (!r_n) begin
      m_valid = 1'b0; m_result = '0; m_cout = 1'b0; m_zero = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        model_op(o, x, y, c, r, co);
        m_result = r;
        m_cout   = co;
        m_zero   = (r == 0);
      end
    end
    #1;
    check({tag, ".valid"},  64'(out_valid), 64'(m_valid));
    check({tag, ".result"}, 64'(result),    64'(m_result));
    check({tag, ".cout"},   64'(cout),      64'(m_cout));
    check({tag, ".zero"},   64'(zero),      64'(m_zero));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h0000_0001;
      3: return 32'h8000_0000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 2'd0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    cycle("rst0", 1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
    cycle("rst1", 1'b0, 1'b0, 2'd0, '0, '0, 1'b0);
    check("rst.zero_const", 64'(zero), 64'd0);

    // Directed vectors
    cycle("add5p3",   1'b1, 1'b1, 2'd0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    check("add5p3.exact", 64'(result), 64'h8);
    cycle("addwrap",  1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("addwrap.exact", 64'({cout, zero, result}), {30'd0, 2'b11, 32'h0});
    cycle("addmax",   1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("addmax.exact", 64'({cout, result}), {31'd0, 1'b1, 32'hFFFF_FFFF});
    cycle("and",      1'b1, 1'b1, 2'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    check("and.exact", 64'(result), 64'hF000_F000);
    cycle("not",      1'b1, 1'b1, 2'd2, 32'h0000_FFFF, 32'h1234_5678, 1'b1);
    check("not.exact", 64'(result), 64'hFFFF_0000);
    cycle("rsvd",     1'b1, 1'b1, 2'd3, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);

    // Back-to-back stream then an idle cycle holding the last result
    cycle("s_add",  1'b1, 1'b1, 2'd0, 32'h0000_0010, 32'h0000_0020, 1'b1);
    cycle("s_and",  1'b1, 1'b1, 2'd1, 32'h0000_00FF, 32'h0000_0F0F, 1'b0);
    cycle("s_not",  1'b1, 1'b1, 2'd2, 32'hAAAA_5555, 32'h0,         1'b0);
    cycle("s_idle", 1'b1, 1'b0, 2'd0, 32'h1111_1111, 32'h2222_2222, 1'b1);
    check("s_idle.held", 64'(result), 64'h5555_AAAA);

    // Reset overrides a valid ADD 1+1 mid-stream
    cycle("pre_rst", 1'b1, 1'b1, 2'd0, 32'h7, 32'h8, 1'b0);
    cycle("rst_mid", 1'b0, 1'b1, 2'd0, 32'h1, 32'h1, 1'b0);
    cycle("post_rst", 1'b1, 1'b1, 2'd0, 32'h1, 32'h1, 1'b0);
    check("post_rst.exact", 64'(result), 64'h2);

    // Randomized traffic
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] o;
      o = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cycle("rand",
            ($urandom_range(0, 49) != 0),
            ($urandom_range(0, 4) != 0),
            o, rand_operand(), rand_operand(), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_adder_and_not_32
`default_nettype wire
